// File: rtl/inv_keysched_pkg.sv
// Shared AES definitions for the backward key schedule.
//   sbox_t     : 256-entry byte table, entry i is the forward S-box output for byte value i
//   SBOX       : forward AES S-box constant in that layout
//   RCON_LAST  : round constant used to derive round 10 from round 9
//   AES128_ROUNDS : number of rounds for AES-128
//   state_e    : scheduler FSM states
package inv_keysched_pkg;

    typedef logic [255:0][7:0] sbox_t;

    localparam logic [7:0] RCON_LAST     = 8'h36;
    localparam logic [3:0] AES128_ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StFin
    } state_e;

    // Table written in reading order: byte value 0x00 occupies the top bits.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Re-pack so that SBOX[b] is the substitution of byte value b.
    function automatic sbox_t gen_sbox();
        sbox_t tbl;
        for (int i = 0; i < 256; i++) begin
            tbl[i] = SBOX_FLAT[2047 - 8 * i -: 8];
        end
        return tbl;
    endfunction

    localparam sbox_t SBOX = gen_sbox();

endpackage

// File: rtl/inv_keystep.sv
// One backward step of the AES-128 key expansion (purely combinational).
//   key_i      : round key N, word 0 in bits [127:96]
//   rcon_i     : round constant that was used to produce key N
//   sbox_i     : forward S-box, indexed by byte value
//   prev_key_o : round key N-1, same word order
module inv_keystep
    import inv_keysched_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  sbox_t        sbox_i,
    output logic [127:0] prev_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;

    assign w0 = key_i[127:96];
    assign w1 = key_i[95:64];
    assign w2 = key_i[63:32];
    assign w3 = key_i[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // RotWord moves the leading byte to the tail.
    assign rot = {p3[23:0], p3[31:24]};

    assign sub = {sbox_i[rot[31:24]], sbox_i[rot[23:16]],
                  sbox_i[rot[15:8]],  sbox_i[rot[7:0]]};

    assign p0 = w0 ^ sub ^ {rcon_i, 24'h0};

    assign prev_key_o = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_keysched.sv
// AES-128 backward key scheduler: starting from the round-10 key, emits round keys 10..0
// over a valid/ready interface, one round per accepted key.
//   eph1     : clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : load last_key and (re)start a schedule; wins over any handshake
//   last_key : round-10 key
//   SBOX     : forward S-box table
//   rk_ready : consumer accepts rk
//   rk_valid : rk / rk_round valid (EMIT state)
//   rk       : current round key
//   rk_round : round index of rk
//   busy     : high in EMIT
//   done     : one-cycle pulse after round 0 is accepted
module inv_keysched
    import inv_keysched_pkg::*;
(
    input  logic         eph1,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    input  sbox_t        SBOX,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    state_e       state_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic [127:0] prev_key;
    logic         hs;

    inv_keystep u_step (
        .key_i      (rk_q),
        .rcon_i     (rcon_q),
        .sbox_i     (SBOX),
        .prev_key_o (prev_key)
    );

    assign hs = (state_q == StEmit) && rk_ready;

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else if (start) begin
            state_q <= StEmit;
            rk_q    <= last_key;
            round_q <= AES128_ROUNDS;
            rcon_q  <= RCON_LAST;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StIdle;
                StEmit: begin
                    if (hs) begin
                        if (round_q == 4'd0) begin
                            // Last key accepted: counter stays at 0.
                            state_q <= StFin;
                        end else begin
                            rk_q    <= prev_key;
                            round_q <= round_q - 4'd1;
                            // Walks back through 36,1b,80,40,...,01.
                            rcon_q  <= (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rk_valid = (state_q == StEmit);
    assign busy     = (state_q == StEmit);
    assign done     = (state_q == StFin);
    assign rk       = rk_q;
    assign rk_round = round_q;

endmodule

// File: tb/tb_inv_keysched.sv
// Directed self-checking bench for inv_keysched using the FIPS-197 example key schedule.
module tb_inv_keysched;
    import inv_keysched_pkg::*;

    logic         eph1;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    logic [127:0] keys [0:10];
    int           n_chk;
    int           n_pass;

    inv_keysched dut (
        .eph1     (eph1),
        .reset    (reset),
        .start    (start),
        .last_key (last_key),
        .SBOX     (SBOX),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        eph1 = 1'b0;
        forever #5 eph1 = ~eph1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic do_start();
        start    = 1'b1;
        last_key = keys[10];
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int r;
        int vcnt;
        n_chk  = 0;
        n_pass = 0;

        keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset    = 1'b0;
        start    = 1'b0;
        last_key = '0;
        rk_ready = 1'b0;

        // Reset values while reset is held.
        #3;
        chk("rst_valid", {127'h0, rk_valid}, 128'h0);
        chk("rst_rk",    rk,                 128'h0);
        chk("rst_round", {124'h0, rk_round}, 128'h0);
        chk("rst_busy",  {127'h0, busy},     128'h0);
        chk("rst_done",  {127'h0, done},     128'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle_valid", {127'h0, rk_valid}, 128'h0);

        // Full run with rk_ready always high.
        rk_ready = 1'b1;
        do_start();
        for (int k = 10; k >= 0; k--) begin
            chk("s1_key",   rk,                 keys[k]);
            chk("s1_round", {124'h0, rk_round}, 128'(k));
            chk("s1_valid", {127'h0, rk_valid}, 128'h1);
            chk("s1_busy",  {127'h0, busy},     128'h1);
            chk("s1_done",  {127'h0, done},     128'h0);
            tick();
        end
        chk("s1_done_pulse", {127'h0, done},     128'h1);
        chk("s1_fin_valid",  {127'h0, rk_valid}, 128'h0);
        chk("s1_fin_busy",   {127'h0, busy},     128'h0);
        tick();
        chk("s1_done_low",   {127'h0, done},     128'h0);

        // rk_ready toggling 1/0: same keys, each held until accepted.
        rk_ready = 1'b1;
        do_start();
        r    = 10;
        vcnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!rk_valid) break;
            vcnt++;
            chk("s2_key",   rk,                 keys[r]);
            chk("s2_round", {124'h0, rk_round}, 128'(r));
            if (rk_ready) r--;
            tick();
            rk_ready = ~rk_ready;
        end
        chk("s2_vcnt", 128'(vcnt), 128'd21);
        chk("s2_done", {127'h0, done}, 128'h1);
        tick();

        // Restart at round 5, then stall 20 cycles at round 10.
        rk_ready = 1'b1;
        do_start();
        repeat (5) tick();
        chk("s3_round5", {124'h0, rk_round}, 128'd5);
        chk("s3_key5",   rk,                 keys[5]);
        start    = 1'b1;
        rk_ready = 1'b0;
        tick();
        start    = 1'b0;
        chk("s3_rst_key",   rk,                 keys[10]);
        chk("s3_rst_round", {124'h0, rk_round}, 128'd10);
        chk("s3_rst_done",  {127'h0, done},     128'h0);
        for (int k = 0; k < 20; k++) begin
            chk("s6_hold_key",  rk,             keys[10]);
            chk("s6_hold_busy", {127'h0, busy}, 128'h1);
            chk("s6_hold_done", {127'h0, done}, 128'h0);
            tick();
        end
        // Next key depends on rcon still being 36 after the stall.
        rk_ready = 1'b1;
        tick();
        rk_ready = 1'b0;
        chk("s6_key9",   rk,                 keys[9]);
        chk("s6_round9", {124'h0, rk_round}, 128'd9);
        rk_ready = 1'b1;
        repeat (9) tick();
        chk("s6_key0", rk, keys[0]);
        tick();
        chk("s6_done", {127'h0, done}, 128'h1);
        tick();

        // Asynchronous reset mid-run at round 3.
        rk_ready = 1'b1;
        do_start();
        repeat (7) tick();
        chk("s4_round3", {124'h0, rk_round}, 128'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("s4_valid", {127'h0, rk_valid}, 128'h0);
        chk("s4_rk",    rk,                 128'h0);
        chk("s4_busy",  {127'h0, busy},     128'h0);
        chk("s4_round", {124'h0, rk_round}, 128'h0);
        chk("s4_done",  {127'h0, done},     128'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s4_idle_valid", {127'h0, rk_valid}, 128'h0);
            chk("s4_idle_done",  {127'h0, done},     128'h0);
        end

        // Start coinciding with the round-7 handshake.
        rk_ready = 1'b1;
        do_start();
        repeat (3) tick();
        chk("s5_round7", {124'h0, rk_round}, 128'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5_round10", {124'h0, rk_round}, 128'd10);
        chk("s5_key10",   rk,                 keys[10]);
        repeat (10) tick();
        chk("s5_key0", rk, keys[0]);
        tick();
        chk("s5_done", {127'h0, done}, 128'h1);
        tick();
        chk("s5_done_low", {127'h0, done},     128'h0);
        chk("s5_idle",     {127'h0, rk_valid}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inv_keysched.md
INV_KEYSCHED -- requirements
Module: inv_keysched

Interface
REQ-001 SHALL have port eph1, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port start, input, 1: single-cycle request to begin a backward schedule.
REQ-004 SHALL have port last_key, input, 128: AES-128 round-10 key, sampled only when start=1; word 0 = bits [127:96].
REQ-005 SHALL have port SBOX, input, [255:0][7:0]: forward S-box, indexed by byte value.
REQ-006 SHALL have port rk_ready, input, 1: consumer accepts rk this cycle.
REQ-007 SHALL have port rk_valid, output, 1: rk/rk_round hold a valid round key.
REQ-008 SHALL have port rk, output, 128: current round key, same word order as last_key.
REQ-009 SHALL have port rk_round, output, 4: round index of rk, 10 down to 0.
REQ-010 SHALL have port busy, output, 1: high in EMIT state.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after round 0 is accepted.

Function
REQ-012 SHALL implement states IDLE, EMIT, FIN.
- IDLE: start=1 -> EMIT.
- EMIT: round-0 handshake -> FIN.
- FIN: -> IDLE after one cycle.
REQ-013 SHALL, on start=1 in any state, load rk=last_key, rk_round=10, rcon=8'h36 and enter EMIT next cycle; this restarts any run in progress.
REQ-014 SHALL assert rk_valid exactly while in EMIT; first valid is the cycle after start (latency 1).
REQ-015 SHALL treat a handshake as rk_valid & rk_ready at a rising edge; without a handshake, rk, rk_round and rcon SHALL hold.
REQ-016 SHALL, on a handshake with rk_round>0, compute the previous key from W0..W3 as follows, registered into rk the next cycle (one round per cycle):
- P3 = W3^W2
- P2 = W2^W1
- P1 = W1^W0
- P0 = W0^SubWord(RotWord(P3))^{rcon,24'h0}
REQ-017 SHALL decrement rk_round on each such handshake and update rcon as: 8'h1b -> 8'h80, otherwise rcon>>1.
REQ-018 SHALL, on the handshake with rk_round=0, leave EMIT, pulse done in FIN, and never underflow rk_round.
REQ-019 SHALL give start priority over a handshake occurring in the same cycle.
REQ-020 SHALL drive done=0 in IDLE and EMIT.
REQ-021 SHALL keep rk stable while rk_valid=1 and no handshake occurs.

Reset
REQ-022 SHALL, while reset=0, force IDLE, rk=0, rk_round=0, rcon=0, rk_valid=0, busy=0, done=0.
REQ-023 SHALL abort any run on reset mid-operation, with no done pulse.
REQ-024 SHALL require a fresh start after reset releases.

Structure
REQ-025 SHALL take the following from the shared AES package: SBOX constant, RCON_LAST=8'h36, AES-128 round count 10, state enum.
REQ-026 SHALL place the one-round backward step in combinational sub-module inv_keystep (inputs key, rcon, SBOX; output previous key).
REQ-027 SHALL keep the FSM, counter, rcon register and handshake in inv_keysched.

Verification
REQ-028 SHALL cover this scenario: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 constantly -> rounds 10..0 on 11 consecutive cycles; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses 1 cycle after round 0.
REQ-029 SHALL cover this scenario: same key, rk_ready toggling 1/0 each cycle -> identical key sequence, each key held stable while unaccepted, 21 valid cycles total.
REQ-030 SHALL cover this scenario: start asserted again while rk_round=5 -> next cycle rk=last_key, rk_round=10, no done pulse from the aborted run.
REQ-031 SHALL cover this scenario: reset=0 while rk_round=3 -> rk_valid=0, rk=0, busy=0 immediately (asynchronous); after release, stays IDLE until start.
REQ-032 SHALL cover this scenario: start in the same cycle as a round-7 handshake -> restart wins, rk_round=10 next cycle.
REQ-033 SHALL cover this scenario: rk_ready held 0 for 20 cycles at round 10 -> rk unchanged, rcon stays 8'h36, busy=1 throughout.
